// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive output stage.
package uart_rx_pkg;

  // Per-frame error flags as reported by the receiver.
  typedef struct packed {
    logic perror;
    logic ferror;
  } rx_err_t;

  localparam rx_err_t RX_ERR_NONE = '{perror: 1'b0, ferror: 1'b0};

  // Width needed to hold an occupancy of 0..depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO with registered occupancy, valid and full flags.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;
  logic [CNT_W-1:0] count_nxt;

  // Accept a push when space exists or the head leaves in the same cycle.
  always_comb begin
    pop_en    = pop & valid;
    push_en   = push & (~full | pop_en);
    count_nxt = count;
    if (push_en && !pop_en) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push_en && pop_en) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Pointers and occupancy flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      valid <= (count_nxt != '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  // Storage array, cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive output stage: filters errored frames, buffers good ones behind
// a valid/ready handshake, and keeps saturating error counters plus a sticky
// overrun flag. Optional macro RX_KEEP_ERRORED_EN stores errored frames too and
// exposes their flags on Rx_ERR.
module uart_rx_buffer
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned COUNT_W = count_width(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  Rx_data,
  input  logic               Rx_valid,
  input  logic               Rx_perror,
  input  logic               Rx_ferror,
  output logic [DATA_W-1:0]  Rx_DATA,
  output logic               Rx_VALID,
  input  logic               Rx_READY,
  output logic [COUNT_W-1:0] Rx_COUNT,
  output logic               Rx_OVERRUN,
  output logic [CNT_W-1:0]   Rx_PERR_CNT,
  output logic [CNT_W-1:0]   Rx_FERR_CNT,
  input  logic               Rx_CLEAR
`ifdef RX_KEEP_ERRORED_EN
  ,
  output rx_err_t            Rx_ERR
`endif
);

`ifdef RX_KEEP_ERRORED_EN
  localparam int unsigned PAYLOAD_W = DATA_W + 2;
`else
  localparam int unsigned PAYLOAD_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rx_err_t              err_in;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 drop;
  logic [PAYLOAD_W-1:0] push_data;
  logic [PAYLOAD_W-1:0] head_data;

  // Frame filtering and handshake decode.
  always_comb begin
    err_in = '{perror: Rx_perror, ferror: Rx_ferror};
`ifdef RX_KEEP_ERRORED_EN
    push      = Rx_valid;
    push_data = {err_in, Rx_data};
`else
    push      = Rx_valid & (err_in == RX_ERR_NONE);
    push_data = Rx_data;
`endif
    pop  = Rx_VALID & Rx_READY;
    drop = push & full & ~pop;
  end

  uart_rx_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .valid     (Rx_VALID),
    .full      (full),
    .count     (Rx_COUNT)
  );

`ifdef RX_KEEP_ERRORED_EN
  assign Rx_DATA = head_data[DATA_W-1:0];
  assign Rx_ERR  = rx_err_t'(head_data[DATA_W +: 2]);
`else
  assign Rx_DATA = head_data;
`endif

  // Sticky overrun and saturating error counters; clear wins over new events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rx_OVERRUN  <= 1'b0;
      Rx_PERR_CNT <= '0;
      Rx_FERR_CNT <= '0;
    end else if (Rx_CLEAR) begin
      Rx_OVERRUN  <= 1'b0;
      Rx_PERR_CNT <= '0;
      Rx_FERR_CNT <= '0;
    end else begin
      if (drop) Rx_OVERRUN <= 1'b1;
      if (Rx_valid && Rx_perror && (Rx_PERR_CNT != CNT_MAX)) begin
        Rx_PERR_CNT <= Rx_PERR_CNT + CNT_W'(1);
      end
      if (Rx_valid && Rx_ferror && (Rx_FERR_CNT != CNT_MAX)) begin
        Rx_FERR_CNT <= Rx_FERR_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer (DEPTH=4); a second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid, rx_perror, rx_ferror, rx_ready, rx_clear;

  logic [7:0] out_data;
  logic       out_valid, out_ovr;
  logic [2:0] out_count;
  logic [7:0] out_pc, out_fc;

  logic [7:0] s_data;
  logic       s_valid, s_ovr;
  logic [2:0] s_count;
  logic [1:0] s_pc, s_fc;

`ifdef RX_KEEP_ERRORED_EN
  logic [1:0] out_err, s_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_buffer #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .Rx_data(rx_data), .Rx_valid(rx_valid),
    .Rx_perror(rx_perror), .Rx_ferror(rx_ferror), .Rx_DATA(out_data),
    .Rx_VALID(out_valid), .Rx_READY(rx_ready), .Rx_COUNT(out_count),
    .Rx_OVERRUN(out_ovr), .Rx_PERR_CNT(out_pc), .Rx_FERR_CNT(out_fc),
    .Rx_CLEAR(rx_clear)
`ifdef RX_KEEP_ERRORED_EN
    , .Rx_ERR(out_err)
`endif
  );

  uart_rx_buffer #(.DATA_W(8), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Rx_data(rx_data), .Rx_valid(rx_valid),
    .Rx_perror(rx_perror), .Rx_ferror(rx_ferror), .Rx_DATA(s_data),
    .Rx_VALID(s_valid), .Rx_READY(rx_ready), .Rx_COUNT(s_count),
    .Rx_OVERRUN(s_ovr), .Rx_PERR_CNT(s_pc), .Rx_FERR_CNT(s_fc),
    .Rx_CLEAR(rx_clear)
`ifdef RX_KEEP_ERRORED_EN
    , .Rx_ERR(s_err)
`endif
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       pe, fe, rdy, clr;
    logic [2:0] cnt;
    logic       vld;
    logic [7:0] dat;
    logic       ovr;
    logic [7:0] pc, fc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic pe,
                       input logic fe, input logic rdy, input logic clr);
    rx_valid = v; rx_data = d; rx_perror = pe; rx_ferror = fe;
    rx_ready = rdy; rx_clear = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic pe, input logic fe,
                     input logic rdy, input logic clr, input logic [2:0] cnt, input logic vld,
                     input logic [7:0] dat, input logic ovr, input logic [7:0] pc,
                     input logic [7:0] fc);
    vec_t r;
    r.v = v; r.d = d; r.pe = pe; r.fe = fe; r.rdy = rdy; r.clr = clr;
    r.cnt = cnt; r.vld = vld; r.dat = dat; r.ovr = ovr; r.pc = pc; r.fc = fc;
    vq.push_back(r);
  endtask

  // Scoreboard model state for the random phase
  logic [9:0] q[$];
  logic       m_ovr;
  logic [7:0] m_pc, m_fc;

  initial begin
    reset = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);

    // Vector table: inputs applied for one edge, then outputs expected after it
    add(1,8'h41,0,0,0,0, 1,1,8'h41,0,0,0);
    add(1,8'h42,0,0,0,0, 2,1,8'h41,0,0,0);
    add(0,8'h00,0,0,1,0, 1,1,8'h42,0,0,0);
    add(0,8'h00,0,0,1,0, 0,0,8'h00,0,0,0);
    add(0,8'h00,0,0,0,0, 0,0,8'h00,0,0,0);
    add(1,8'h01,0,0,0,0, 1,1,8'h01,0,0,0);
    add(1,8'h02,0,0,0,0, 2,1,8'h01,0,0,0);
    add(1,8'h03,0,0,0,0, 3,1,8'h01,0,0,0);
    add(1,8'h04,0,0,0,0, 4,1,8'h01,0,0,0);
    add(1,8'h05,0,0,0,0, 4,1,8'h01,1,0,0);
    add(0,8'h00,0,0,1,0, 3,1,8'h02,1,0,0);
    add(0,8'h00,0,0,1,0, 2,1,8'h03,1,0,0);
    add(0,8'h00,0,0,1,0, 1,1,8'h04,1,0,0);
    add(0,8'h00,0,0,1,0, 0,0,8'h00,1,0,0);
    add(0,8'h00,0,0,0,1, 0,0,8'h00,0,0,0);
    add(1,8'h11,0,0,0,0, 1,1,8'h11,0,0,0);
    add(1,8'h12,0,0,0,0, 2,1,8'h11,0,0,0);
    add(1,8'h13,0,0,0,0, 3,1,8'h11,0,0,0);
    add(1,8'h14,0,0,0,0, 4,1,8'h11,0,0,0);
    add(1,8'h15,0,0,1,0, 4,1,8'h12,0,0,0);
    add(0,8'h00,0,0,1,0, 3,1,8'h13,0,0,0);
    add(0,8'h00,0,0,1,0, 2,1,8'h14,0,0,0);
    add(0,8'h00,0,0,1,0, 1,1,8'h15,0,0,0);
    add(0,8'h00,0,0,1,0, 0,0,8'h00,0,0,0);
    add(1,8'h77,1,1,0,0, 0,0,8'h00,0,1,1);
    add(1,8'h78,1,0,0,0, 0,0,8'h00,0,2,1);
    add(1,8'h79,1,0,0,1, 0,0,8'h00,0,0,0);
    add(1,8'h7a,0,1,0,0, 0,0,8'h00,0,0,1);
    add(0,8'h99,1,1,0,0, 0,0,8'h00,0,0,1);
    add(1,8'h5a,0,0,0,0, 1,1,8'h5a,0,0,1);
    add(0,8'h00,0,0,1,0, 0,0,8'h00,0,0,1);
    add(1,8'h66,0,0,1,0, 1,1,8'h66,0,0,1);
    add(0,8'h00,0,0,1,0, 0,0,8'h00,0,0,1);
    add(1,8'h21,0,0,0,0, 1,1,8'h21,0,0,1);
    add(1,8'h22,0,0,0,0, 2,1,8'h21,0,0,1);
    add(1,8'h23,0,0,0,0, 3,1,8'h21,0,0,1);
    add(1,8'h24,0,0,0,0, 4,1,8'h21,0,0,1);
    add(1,8'h25,0,0,0,1, 4,1,8'h21,0,0,0);
    add(0,8'h00,0,0,1,0, 3,1,8'h22,0,0,0);
    add(0,8'h00,0,0,1,0, 2,1,8'h23,0,0,0);
    add(0,8'h00,0,0,1,0, 1,1,8'h24,0,0,0);
    add(0,8'h00,0,0,1,0, 0,0,8'h00,0,0,0);

    // Reset state
    #1;
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset count", 32'(out_count), 32'd0);
    chk("reset data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #4;

`ifndef RX_KEEP_ERRORED_EN
    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].d, vq[i].pe, vq[i].fe, vq[i].rdy, vq[i].clr);
      tick();
      chk($sformatf("row%0d count", i), 32'(out_count), 32'(vq[i].cnt));
      chk($sformatf("row%0d valid", i), 32'(out_valid), 32'(vq[i].vld));
      if (vq[i].vld) chk($sformatf("row%0d data", i), 32'(out_data), 32'(vq[i].dat));
      chk($sformatf("row%0d overrun", i), 32'(out_ovr), 32'(vq[i].ovr));
      chk($sformatf("row%0d perr_cnt", i), 32'(out_pc), 32'(vq[i].pc));
      chk($sformatf("row%0d ferr_cnt", i), 32'(out_fc), 32'(vq[i].fc));
    end
`endif

    // Counter saturation and clear-vs-event priority
    drive(0, 8'h00, 0, 0, 0, 1); tick();
    repeat (5) begin drive(1, 8'hc0, 1, 0, 0, 0); tick(); end
    chk("perr x5 wide", 32'(out_pc), 32'd5);
    chk("perr x5 saturated", 32'(s_pc), 32'd3);
    chk("perr x5 ferr untouched", 32'(s_fc), 32'd0);
`ifndef RX_KEEP_ERRORED_EN
    chk("perr x5 not stored", 32'(out_count), 32'd0);
`endif
    drive(0, 8'h00, 0, 0, 0, 1); tick();
    chk("clear perr", 32'(out_pc), 32'd0);
    repeat (2) begin drive(1, 8'hc1, 1, 0, 0, 0); tick(); end
    chk("perr at 2", 32'(out_pc), 32'd2);
    drive(1, 8'hc2, 1, 0, 0, 1); tick();
    chk("clear beats perr", 32'(out_pc), 32'd0);
    chk("clear beats perr sat", 32'(s_pc), 32'd0);
    repeat (4) begin drive(1, 8'hc3, 0, 1, 0, 0); tick(); end
    chk("ferr x4 wide", 32'(out_fc), 32'd4);
    chk("ferr x4 saturated", 32'(s_fc), 32'd3);

    // Asynchronous reset with frames stored, then strobe during reset
    drive(0, 8'h00, 0, 0, 0, 1); tick();
    drive(1, 8'ha1, 0, 0, 0, 0); tick();
    drive(1, 8'ha2, 0, 0, 0, 0); tick();
    drive(1, 8'ha3, 0, 1, 0, 0); tick();
    drive(1, 8'ha4, 0, 0, 0, 0); tick();
    chk("pre-reset count", 32'(out_count), 32'd3);
    chk("pre-reset ferr", 32'(out_fc), 32'd1);
    drive(0, 8'h00, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("async reset valid", 32'(out_valid), 32'd0);
    chk("async reset count", 32'(out_count), 32'd0);
    chk("async reset data", 32'(out_data), 32'd0);
    chk("async reset overrun", 32'(out_ovr), 32'd0);
    chk("async reset ferr", 32'(out_fc), 32'd0);
    drive(1, 8'h33, 0, 0, 0, 0); tick();
    #3 reset = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0); tick();
    chk("strobe in reset lost", 32'(out_count), 32'd0);
    drive(1, 8'h34, 0, 0, 0, 0); tick();
    chk("post-reset push count", 32'(out_count), 32'd1);
    chk("post-reset push data", 32'(out_data), 32'h34);
    drive(0, 8'h00, 0, 0, 1, 0); tick();
    chk("post-reset drained", 32'(out_valid), 32'd0);

`ifdef RX_KEEP_ERRORED_EN
    drive(1, 8'h55, 0, 1, 0, 0); tick();
    chk("keep count", 32'(out_count), 32'd1);
    chk("keep data", 32'(out_data), 32'h55);
    chk("keep err", 32'(out_err), 32'd1);
    chk("keep ferr cnt", 32'(out_fc), 32'd1);
    drive(0, 8'h00, 0, 0, 1, 0); tick();
    chk("keep drained", 32'(out_count), 32'd0);
`endif

    // Random traffic against a queue scoreboard
    drive(0, 8'h00, 0, 0, 0, 1); tick();
    m_ovr = 1'b0; m_pc = '0; m_fc = '0;
    for (int n = 0; n < 300; n++) begin
      logic v, pe, fe, rdy, clr, push_m, ovr_ev;
      logic [7:0] d;
      logic [9:0] hd;
      v   = ($urandom_range(0, 9) < 7);
      d   = 8'($urandom_range(0, 255));
      pe  = ($urandom_range(0, 5) == 0);
      fe  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 40) == 0);
      drive(v, d, pe, fe, rdy, clr);
      if (q.size() != 0 && rdy) begin
        hd = q.pop_front();
        chk("sb pop data", 32'(out_data), 32'(hd[7:0]));
`ifdef RX_KEEP_ERRORED_EN
        chk("sb pop err", 32'(out_err), 32'(hd[9:8]));
`endif
      end
`ifdef RX_KEEP_ERRORED_EN
      push_m = v;
`else
      push_m = v && !pe && !fe;
`endif
      ovr_ev = 1'b0;
      if (push_m) begin
        if (q.size() < 4) q.push_back({pe, fe, d});
        else ovr_ev = 1'b1;
      end
      if (clr) begin
        m_ovr = 1'b0; m_pc = '0; m_fc = '0;
      end else begin
        if (ovr_ev) m_ovr = 1'b1;
        if (v && pe && m_pc != 8'hff) m_pc = m_pc + 8'd1;
        if (v && fe && m_fc != 8'hff) m_fc = m_fc + 8'd1;
      end
      tick();
      chk("sb count", 32'(out_count), 32'(q.size()));
      chk("sb valid", 32'(out_valid), 32'(q.size() != 0));
      chk("sb overrun", 32'(out_ovr), 32'(m_ovr));
      chk("sb perr_cnt", 32'(out_pc), 32'(m_pc));
      chk("sb ferr_cnt", 32'(out_fc), 32'(m_fc));
      if (q.size() != 0) chk("sb head", 32'(out_data), 32'(q[0][7:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Parametrised receive output stage of the UART path: takes the per-frame strobe, data and parity/framing error flags from the UART receiver, drops errored frames, and buffers good frames in a FIFO presented to the consumer (LED driver or host logic) over a valid/ready handshake. It also keeps saturating parity/framing error counters and a sticky overrun flag. It supersedes the combinational receive-output stage, which had no buffering and no backpressure.

## Interface
- DATA_W, 8, frame data width in bits (5..9)
- DEPTH, 4, FIFO depth in frames; power of two, >= 2
- CNT_W, 8, width of each error counter
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- Rx_data  in  DATA_W  frame data from receiver, qualified by Rx_valid
- Rx_valid  in  1  one-cycle strobe per received frame
- Rx_perror  in  1  parity error for the strobed frame
- Rx_ferror  in  1  framing error for the strobed frame
- Rx_DATA  out  DATA_W  head-of-FIFO data
- Rx_VALID  out  1  FIFO non-empty; Rx_DATA valid
- Rx_READY  in  1  consumer accepts head frame when high with Rx_VALID
- Rx_COUNT  out  $clog2(DEPTH+1)  frames currently stored
- Rx_OVERRUN  out  1  sticky: a good frame was dropped because FIFO was full
- Rx_PERR_CNT  out  CNT_W  saturating count of parity-error frames
- Rx_FERR_CNT  out  CNT_W  saturating count of framing-error frames
- Rx_CLEAR  in  1  synchronous clear of Rx_OVERRUN and both counters

## Operation
- Frame sampled only in cycles with Rx_valid=1; Rx_data/error inputs ignored otherwise.
- Good frame (Rx_perror=0, Rx_ferror=0): pushed to FIFO tail.
- Errored frame: not pushed; Rx_PERR_CNT += Rx_perror, Rx_FERR_CNT += Rx_ferror (both may increment in one cycle). Counters saturate at 2^CNT_W-1, never wrap.
- Pop: Rx_VALID & Rx_READY in a cycle removes the head at that clock edge.
- Full, no pop, good frame: frame discarded, Rx_OVERRUN set; stored contents untouched.
- Full, pop and good frame same cycle: both happen, Rx_COUNT unchanged, no overrun.
- Empty and good frame: push only; no same-cycle bypass.
- Read/write pointers are log2(DEPTH) bits and wrap naturally; Rx_COUNT tracks occupancy 0..DEPTH.
- Rx_CLEAR: zeroes Rx_OVERRUN, Rx_PERR_CNT, Rx_FERR_CNT; wins over a same-cycle error or overrun event (that event is not recorded). FIFO contents unaffected.
- Rx_DATA is don't-care while Rx_VALID=0; it must not change while Rx_VALID=1 and Rx_READY=0.

## Timing
- Reset (reset=0, async): Rx_VALID=0, Rx_COUNT=0, Rx_DATA=0, Rx_OVERRUN=0, both counters 0, pointers 0. Frame strobed during reset is lost.
- Latency: good frame strobed at edge N -> Rx_VALID=1, Rx_DATA=frame after edge N (first-word fall-through, one cycle).
- Throughput: one push and one pop per cycle.
- Rx_VALID, Rx_COUNT, Rx_OVERRUN, counters are registered outputs; no combinational path from Rx_READY to any output.
- Reset release mid-frame: receiver strobes after deassertion are processed normally.

## Configuration
- RX_KEEP_ERRORED_EN defined: errored frames are also pushed; extra output Rx_ERR out 2 ({perror, ferror}) travels with Rx_DATA; counters still increment; full-FIFO drop of any frame sets Rx_OVERRUN.
- Undefined: Rx_ERR port absent; errored frames discarded as above.

## Structure
- Package uart_rx_pkg: rx_err_t (2-bit {perror, ferror}), RX_ERR_NONE constant, helper function for count width.
- One sub-module uart_rx_fifo (DATA_W/DEPTH generic storage, push/pop/count); top holds filtering, counters, overrun.

## Test plan
- Reset, push 0x41, 0x42 with Rx_READY=0 -> Rx_VALID=1 next cycle, Rx_DATA=0x41, Rx_COUNT=2; raise Rx_READY -> 0x41 then 0x42, then Rx_VALID=0.
- DEPTH=4: push 5 good frames, no pop -> Rx_COUNT=4, Rx_OVERRUN=1, pop order 1..4, fifth lost.
- Full FIFO, push and pop same cycle -> Rx_COUNT stays 4, Rx_OVERRUN=0, new frame appears last.
- Frame with perror=1 and ferror=1 -> both counters 1, Rx_COUNT unchanged; CNT_W=2 with 5 parity errors -> Rx_PERR_CNT=3.
- Rx_CLEAR same cycle as parity error with counter=2 -> counter 0; assert reset with 3 frames stored -> all outputs at reset values immediately.
- RX_KEEP_ERRORED_EN: frame 0x55 with ferror=1 -> stored, Rx_ERR=2'b01 alongside 0x55, Rx_FERR_CNT=1.
